// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU sharing controller.
// Optional feature macro: ALU_SHARE_FLAGREG_EN (architectural flag register).
package alu_share_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // ALU select encodings: S[3]=0 arithmetic (S[0] picks subtract), S[3]=1 logic on S[2:0]
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;
  localparam logic [3:0] OP_PASSA = 4'b1100;
  localparam logic [3:0] OP_PASSB = 4'b1101;
  localparam logic [3:0] OP_NAND  = 4'b1110;
  localparam logic [3:0] OP_NOR   = 4'b1111;

  // Widest datapath and grant index the latched request can carry
  localparam int MAX_BITS = 64;
  localparam int MAX_IDW  = 3;

  // Request captured at grant time; it alone drives the ALU afterwards
  typedef struct packed {
    logic [3:0]          op;
    logic [MAX_BITS-1:0] a;
    logic [MAX_BITS-1:0] b;
    logic [MAX_IDW-1:0]  id;
    logic                setf;
  } req_t;

endpackage

// File: rtl/alu.sv
// Shared ALU datapath: arithmetic add/sub and eight logic ops, flags {N,Z,C,V}.
// C is the carry out (no-borrow on subtract); C and V stay 0 for logic ops.
module alu
  import alu_share_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [3:0]      s,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] y,
  output logic [3:0]      nzcv
);

  logic [BITS:0] sum;
  logic          c;
  logic          v;

  // Decode the select and compute result, carry and signed overflow
  always_comb begin
    sum = '0;
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    if (s[3] == 1'b0) begin
      case ({3'b000, s[0]})
        OP_ADD: begin
          sum = {1'b0, a} + {1'b0, b};
          v   = (a[BITS-1] == b[BITS-1]) && (sum[BITS-1] != a[BITS-1]);
        end
        OP_SUB: begin
          sum = {1'b0, a} + {1'b0, ~b} + (BITS+1)'(1);
          v   = (a[BITS-1] != b[BITS-1]) && (sum[BITS-1] != a[BITS-1]);
        end
        default: sum = '0;
      endcase
      y = sum[BITS-1:0];
      c = sum[BITS];
    end else begin
      case ({1'b1, s[2:0]})
        OP_AND:   y = a & b;
        OP_OR:    y = a | b;
        OP_XOR:   y = a ^ b;
        OP_NOT:   y = ~a;
        OP_PASSA: y = a;
        OP_PASSB: y = b;
        OP_NAND:  y = ~(a & b);
        OP_NOR:   y = ~(a | b);
        default:  y = '0;
      endcase
    end
  end

  assign nzcv = {y[BITS-1], (y == '0), c, v};

endmodule

// File: rtl/rr_arbiter_nreq.sv
// Combinational round-robin arbiter: first valid requester at or above ptr, wrapping.
module rr_arbiter_nreq #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  logic [IDW-1:0] idx;

  // Scan from the pointer upward with wrap and keep the first hit
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = IDW'((int'(ptr) + off) % NREQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU among NREQ requesters: round-robin grant, one-cycle execute,
// registered response held until its owner accepts it.
// Optional macro ALU_SHARE_FLAGREG_EN adds req_setf and the flags_q register.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int BITS = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [BITS*NREQ-1:0] req_a,
  input  logic [BITS*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [BITS-1:0]   rsp_y,
  output logic [3:0]        rsp_nzcv,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
`ifdef ALU_SHARE_FLAGREG_EN
  ,
  input  logic [NREQ-1:0]   req_setf,
  output logic [3:0]        flags_q
`endif
);

  state_e         state_q, state_d;
  req_t           req_q, req_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [BITS-1:0] rsp_y_q, rsp_y_d;
  logic [3:0]     rsp_nzcv_q, rsp_nzcv_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [BITS-1:0] alu_y;
  logic [3:0]      alu_nzcv;
  logic            unused_req_bits;

  logic [3:0]      op_arr [NREQ];
  logic [BITS-1:0] a_arr  [NREQ];
  logic [BITS-1:0] b_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[4*g +: 4];
    assign a_arr[g]  = req_a[BITS*g +: BITS];
    assign b_arr[g]  = req_b[BITS*g +: BITS];
  end

  rr_arbiter_nreq #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  alu #(.BITS(BITS)) u_alu (
    .s    (req_q.op),
    .a    (req_q.a[BITS-1:0]),
    .b    (req_q.b[BITS-1:0]),
    .y    (alu_y),
    .nzcv (alu_nzcv)
  );

  assign rsp_id          = req_q.id[IDW-1:0];
  assign rsp_y           = rsp_y_q;
  assign rsp_nzcv        = rsp_nzcv_q;
  assign unused_req_bits = ^req_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: grant -> execute -> wait for the owner's accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready[rsp_id]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grant only while idle and out of reset, response to the owner only
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != IDLE);
    if (state_q == IDLE && !rst) req_ready = grant;
    if (state_q == RESP) rsp_valid[rsp_id] = 1'b1;
  end

  // Datapath next values: latch the winner, advance the pointer, capture the ALU result
  always_comb begin
    req_d      = req_q;
    ptr_d      = ptr_q;
    rsp_y_d    = rsp_y_q;
    rsp_nzcv_d = rsp_nzcv_q;
    if (state_q == IDLE && grant_any) begin
      req_d.op = op_arr[grant_idx];
      req_d.a  = MAX_BITS'(a_arr[grant_idx]);
      req_d.b  = MAX_BITS'(b_arr[grant_idx]);
      req_d.id = MAX_IDW'(grant_idx);
`ifdef ALU_SHARE_FLAGREG_EN
      req_d.setf = req_setf[grant_idx];
`else
      req_d.setf = 1'b0;
`endif
      ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    end
    if (state_q == EXEC) begin
      rsp_y_d    = alu_y;
      rsp_nzcv_d = alu_nzcv;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      ptr_q      <= '0;
      rsp_y_q    <= '0;
      rsp_nzcv_q <= '0;
    end else begin
      req_q      <= req_d;
      ptr_q      <= ptr_d;
      rsp_y_q    <= rsp_y_d;
      rsp_nzcv_q <= rsp_nzcv_d;
    end
  end

`ifdef ALU_SHARE_FLAGREG_EN
  logic [3:0] flags_d;

  // Architectural flags follow the captured NZCV only for setf operations
  always_comb begin
    flags_d = flags_q;
    if (state_q == EXEC && req_q.setf) flags_d = alu_nzcv;
  end

  // Architectural flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end
`endif

endmodule
